ippcsge_tx_gearbox: RTL and testbench
=====================================

Name: ippcsge_tx_gearbox

Overview:
- Downstream neighbour of the GE PCS transmit path.
- Takes one 10-bit 8b/10b code group per sclk125 cycle and packs pairs of groups into 20-bit words for the SERDES parallel interface, with a one-cycle word-valid strobe.
- Can replace PCS data with built-in test patterns (PRBS7, K28.5 comma stream, square wave) for link bring-up.
- Single clock domain (sclk125).

Parameters:
- BITREV, 0: 1 = reverse bit order inside each 10-bit group before packing (SERDES transmits bit 0 first); 0 = pass through unchanged.
- PRBS_SEED, 7'h7F: PRBS7 seed loaded on reset and on every entry into PRBS mode. Must be non-zero.

Ports:
- sclk125  in  1  125 MHz transmit clock.
- rst  in  1  asynchronous reset, active-high.
- txdi  in  10  code group from PCS transmit, one per cycle, always valid.
- tpmode  in  2  test pattern select, quasi-static: 00 normal, 01 PRBS7, 10 K28.5 stream, 11 square wave 10'b1111100000.
- align_req  in  1  single-cycle pulse; restarts word phase and discards any half-built word.
- txd20  out  20  packed word; first group in [9:0], second in [19:10].
- txd20_vld  out  1  high for exactly one cycle per new txd20.
- phase  out  1  current half-word phase: 0 = next group goes to the low half.
- mode_act  out  2  test mode currently in effect (latched copy of tpmode).

Behaviour:
- Reset values: txd20 = 0, txd20_vld = 0, phase = 0, mode_act = 00, PRBS register = PRBS_SEED, low-half holding register = 0.
- Group source, selected each cycle by mode_act:
  - 00: txdi.
  - 01: next 10 PRBS7 bits (x^7+x^6+1). The LFSR advances 10 bit-steps per cycle. The earliest bit goes in group bit 0, before any BITREV.
  - 10: K28.5 with alternating disparity, starting at RD- (10'b0011111010), then RD+ (10'b1100000101), alternating every group. The toggle is cleared on mode entry.
  - 11: constant 10'b1111100000.
- BITREV is applied after source selection, identically for all modes.
- Phase sequencing:
  - phase toggles every cycle.
  - At phase 0 the selected group is stored in the low-half register.
  - At phase 1 the word {group, lowhalf} is registered into txd20 and txd20_vld = 1 for the following cycle.
  - Latency: group A presented at cycle n (phase 0) and group B at n+1 give txd20 = {B,A} with vld high during cycle n+2.
  - txd20 holds its value between strobes. vld is never high on two consecutive cycles.
- Mode switching:
  - tpmode is sampled into mode_act only on cycles where phase = 0, so a word never mixes sources.
  - Entry into mode 01 reloads PRBS_SEED in the same cycle; the first PRBS group uses the seed state.
  - Entry into mode 10 restarts at RD-.
  - Leaving and re-entering a mode restarts it.
- align_req:
  - In the cycle after the pulse, phase = 0 and the low-half register is cleared.
  - A word whose low half was captured before the pulse is dropped (no vld).
  - If align_req arrives at phase 1, the word is not emitted that cycle.
  - align_req also acts as a phase-0 sampling point for tpmode.
  - PRBS and K28.5 state are not reset by align_req.
  - Back-to-back align_req pulses hold phase at 0 and suppress vld.
- Reset mid-word: all state returns to reset values asynchronously. The first vld after reset deasserts occurs in the 3rd cycle after release.
- An all-zero PRBS state cannot arise; PRBS_SEED = 0 is a configuration error (assertion in the bench).

Decomposition:
- Shared package ippcsge_pkg holds:
  - K28.5 RD- and RD+ constants.
  - Square-wave constant.
  - tpmode encodings (TP_NORM, TP_PRBS7, TP_K285, TP_SQR).
  - PRBS7 tap positions.
- One sub-module: ippcsge_prbs7_gen10. It holds the LFSR, advances 10 steps per enable, has a load input with seed, and outputs 10 bits. The gearbox instantiates it.

Test Plan:
- Normal mode, txdi = 10'h001, 10'h002, 10'h003, 10'h004 from reset release → txd20 = 20'h00801 then 20'h01003, vld pulses 2 cycles apart, first in the 3rd cycle after release.
- BITREV=1, txdi = 10'h001 then 10'h000 → txd20 = 20'h00200.
- tpmode = 10 → txd20 = {10'b1100000101, 10'b0011111010} repeated every vld. Switching to 10 while phase = 1 takes effect only at the next word, with no mixed word.
- tpmode = 01 with PRBS_SEED = 7'h7F → serialized output matches the golden x^7+x^6+1 model, with bit k equal to bit k+127 across 1000 words. Re-entering the mode reproduces the identical first word.
- align_req at phase 1 after low half A captured → no vld for A. The next two groups C,D give txd20 = {D,C}, and phase = 0 the cycle after the pulse.
- rst asserted mid-word with phase = 1 → txd20 = 0, vld = 0, phase = 0, mode_act = 00 immediately (asynchronously); the first vld after release is in the 3rd cycle.

Source files
------------

// File: rtl/ippcsge_pkg.sv
// Shared constants for the GE PCS transmit gearbox: test-pattern code groups,
// tpmode encodings and PRBS7 tap positions.
package ippcsge_pkg;

  localparam logic [9:0] K285_RDM = 10'b0011111010;
  localparam logic [9:0] K285_RDP = 10'b1100000101;
  localparam logic [9:0] SQR_WAVE = 10'b1111100000;

  localparam logic [1:0] TP_NORM  = 2'b00;
  localparam logic [1:0] TP_PRBS7 = 2'b01;
  localparam logic [1:0] TP_K285  = 2'b10;
  localparam logic [1:0] TP_SQR   = 2'b11;

  // x^7 + x^6 + 1: feedback from state bits 6 and 5
  localparam int unsigned PRBS7_TAP_A = 6;
  localparam int unsigned PRBS7_TAP_B = 5;

  function automatic logic [9:0] bitrev10(input logic [9:0] d);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[i] = d[9-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ippcsge_prbs7_gen10.sv
// PRBS7 (x^7+x^6+1) generator producing 10 bits per enabled cycle; earliest bit in data_o[0].
module ippcsge_prbs7_gen10
  import ippcsge_pkg::*;
#(
  parameter logic [6:0] PRBS_SEED = 7'h7F
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [6:0] seed_i,
  output logic [9:0] data_o
);

  logic [6:0] state_q, state_d;
  logic [6:0] st;
  logic       fb;

  // A load seeds this cycle's output directly, so the first group uses the seed state.
  always_comb begin
    st     = load_i ? seed_i : state_q;
    fb     = 1'b0;
    data_o = '0;
    for (int i = 0; i < 10; i++) begin
      fb        = st[PRBS7_TAP_A] ^ st[PRBS7_TAP_B];
      data_o[i] = fb;
      st        = {st[5:0], fb};
    end
    state_d = en_i ? st : state_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PRBS_SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/ippcsge_tx_gearbox.sv
// 10-to-20 bit transmit gearbox with built-in test pattern sources (PRBS7, K28.5, square wave).
module ippcsge_tx_gearbox
  import ippcsge_pkg::*;
#(
  parameter int unsigned BITREV    = 0,
  parameter logic [6:0]  PRBS_SEED = 7'h7F
) (
  input  logic        sclk125,
  input  logic        rst,
  input  logic [9:0]  txdi,
  input  logic [1:0]  tpmode,
  input  logic        align_req,
  output logic [19:0] txd20,
  output logic        txd20_vld,
  output logic        phase,
  output logic [1:0]  mode_act
);

  logic [19:0] txd20_q, txd20_d;
  logic        vld_q, vld_d;
  logic        phase_q, phase_d;
  logic [1:0]  mode_q, mode_sel;
  logic [9:0]  low_q, low_d;
  logic        rd_q, rd_d, rd_cur;
  logic        samp, entry;
  logic [9:0]  prbs_grp, src_grp, grp;

  // Mode only changes at a word boundary (or align), and the new mode drives that same group.
  assign samp     = ~phase_q | align_req;
  assign mode_sel = samp ? tpmode : mode_q;
  assign entry    = samp & (tpmode != mode_q);

  ippcsge_prbs7_gen10 #(
    .PRBS_SEED(PRBS_SEED)
  ) u_prbs (
    .clk_i (sclk125),
    .rst_i (rst),
    .en_i  (mode_sel == TP_PRBS7),
    .load_i(entry && (mode_sel == TP_PRBS7)),
    .seed_i(PRBS_SEED),
    .data_o(prbs_grp)
  );

  always_comb begin
    rd_cur = entry ? 1'b0 : rd_q;
    rd_d   = (mode_sel == TP_K285) ? ~rd_cur : rd_q;
    src_grp = txdi;
    unique case (mode_sel)
      TP_NORM:  src_grp = txdi;
      TP_PRBS7: src_grp = prbs_grp;
      TP_K285:  src_grp = rd_cur ? K285_RDP : K285_RDM;
      TP_SQR:   src_grp = SQR_WAVE;
      default:  src_grp = txdi;
    endcase
    grp = (BITREV != 0) ? bitrev10(src_grp) : src_grp;
  end

  always_comb begin
    txd20_d = txd20_q;
    vld_d   = 1'b0;
    phase_d = ~phase_q;
    low_d   = low_q;
    if (align_req) begin
      phase_d = 1'b0;
      low_d   = '0;
    end else if (!phase_q) begin
      low_d = grp;
    end else begin
      txd20_d = {grp, low_q};
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge sclk125 or posedge rst) begin
    if (rst) begin
      txd20_q <= '0;
      vld_q   <= 1'b0;
      phase_q <= 1'b0;
      mode_q  <= TP_NORM;
      low_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      txd20_q <= txd20_d;
      vld_q   <= vld_d;
      phase_q <= phase_d;
      mode_q  <= mode_sel;
      low_q   <= low_d;
      rd_q    <= rd_d;
    end
  end

  assign txd20     = txd20_q;
  assign txd20_vld = vld_q;
  assign phase     = phase_q;
  assign mode_act  = mode_q;

endmodule

// File: tb/tb_ippcsge_tx_gearbox.sv
// Directed self-checking bench for ippcsge_tx_gearbox (BITREV=0 and BITREV=1 instances).
module tb_ippcsge_tx_gearbox;

  localparam logic [6:0] SEED = 7'h7F;
  localparam int unsigned NWORDS = 1000;

  logic        clk;
  logic        rst;
  logic [9:0]  txdi;
  logic [1:0]  tpmode;
  logic        align_req;
  logic [19:0] txd20, txd20_r;
  logic        vld, vld_r;
  logic        phase, phase_r;
  logic [1:0]  mode_act, mode_act_r;

  int checks = 0;
  int errors = 0;

  logic [6:0]  mst;
  logic [19:0] w0, wexp;
  logic        bits [NWORDS*20];
  int          bad_model, bad_vld, bad_period;

  ippcsge_tx_gearbox #(.BITREV(0), .PRBS_SEED(SEED)) dut (
    .sclk125(clk), .rst(rst), .txdi(txdi), .tpmode(tpmode), .align_req(align_req),
    .txd20(txd20), .txd20_vld(vld), .phase(phase), .mode_act(mode_act)
  );

  ippcsge_tx_gearbox #(.BITREV(1), .PRBS_SEED(SEED)) dut_r (
    .sclk125(clk), .rst(rst), .txdi(txdi), .tpmode(tpmode), .align_req(align_req),
    .txd20(txd20_r), .txd20_vld(vld_r), .phase(phase_r), .mode_act(mode_act_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference x^7+x^6+1 serial model: 20 bits, earliest in bit 0
  task automatic model_word(output logic [19:0] w);
    logic fb;
    w = '0;
    for (int i = 0; i < 20; i++) begin
      fb   = mst[6] ^ mst[5];
      w[i] = fb;
      mst  = {mst[5:0], fb};
    end
  endtask

  initial begin
    if (SEED == 7'h00) $fatal(1, "FAIL config: PRBS_SEED must be non-zero");
    rst = 1'b1; txdi = '0; tpmode = 2'b00; align_req = 1'b0;
    tick(); tick();
    check("rst_txd20", txd20, 20'h0);
    check("rst_vld", {19'h0, vld}, 20'h0);
    check("rst_phase", {19'h0, phase}, 20'h0);
    check("rst_mode", {18'h0, mode_act}, 20'h0);

    // Normal mode from reset release
    rst = 1'b0;
    txdi = 10'h001; tick();
    check("n_ph1", {19'h0, phase}, 20'h1);
    check("n_vld_c1", {19'h0, vld}, 20'h0);
    txdi = 10'h002; tick();
    check("n_vld_c2", {19'h0, vld}, 20'h1);
    check("n_word0", txd20, 20'h00801);
    txdi = 10'h003; tick();
    check("n_vld_gap", {19'h0, vld}, 20'h0);
    check("n_hold", txd20, 20'h00801);
    txdi = 10'h004; tick();
    check("n_vld_c4", {19'h0, vld}, 20'h1);
    check("n_word1", txd20, 20'h01003);

    // Bit reversal
    txdi = 10'h001; tick();
    txdi = 10'h000; tick();
    check("brev_word", txd20_r, 20'h00200);
    check("nobrev_word", txd20, 20'h00001);

    // Square wave
    tpmode = 2'b11; tick(); tick();
    check("sqr_word", txd20, 20'hF83E0);
    check("sqr_mode", {18'h0, mode_act}, 20'h3);

    // K28.5 stream
    tpmode = 2'b10; tick(); tick();
    check("k_word0", txd20, 20'hC14FA);
    tick(); tick();
    check("k_word1", txd20, 20'hC14FA);
    check("k_vld", {19'h0, vld}, 20'h1);

    // Switch to K28.5 while phase = 1: no mixed word
    tpmode = 2'b00;
    txdi = 10'h155; tick();
    txdi = 10'h2AA; tick();
    check("sw_norm", txd20, 20'hAA955);
    txdi = 10'h111; tick();
    tpmode = 2'b10; txdi = 10'h222; tick();
    check("sw_nomix", txd20, 20'h88911);
    check("sw_mode_old", {18'h0, mode_act}, 20'h0);
    tick(); tick();
    check("sw_k_first", txd20, 20'hC14FA);
    check("sw_mode_new", {18'h0, mode_act}, 20'h2);

    // align_req at phase 1 drops the half-built word
    tpmode = 2'b00;
    txdi = 10'h3FF; tick();
    align_req = 1'b1; txdi = 10'h0AB; tick();
    check("al_phase", {19'h0, phase}, 20'h0);
    check("al_novld", {19'h0, vld}, 20'h0);
    align_req = 1'b0; txdi = 10'h123; tick();
    check("al_novld2", {19'h0, vld}, 20'h0);
    txdi = 10'h321; tick();
    check("al_word", txd20, 20'hC8523);
    check("al_vld", {19'h0, vld}, 20'h1);
    align_req = 1'b1; tick();
    check("al_b2b_ph0", {19'h0, phase}, 20'h0);
    check("al_b2b_vld0", {19'h0, vld}, 20'h0);
    tick();
    check("al_b2b_ph1", {19'h0, phase}, 20'h0);
    check("al_b2b_vld1", {19'h0, vld}, 20'h0);
    align_req = 1'b0;

    // PRBS7: model comparison and 127-bit periodicity
    tpmode = 2'b01; mst = SEED;
    bad_model = 0; bad_vld = 0; bad_period = 0;
    for (int w = 0; w < NWORDS; w++) begin
      tick();
      if (vld !== 1'b0) bad_vld++;
      tick();
      if (vld !== 1'b1) bad_vld++;
      model_word(wexp);
      if (w == 0) begin
        w0 = txd20;
        check("prbs_first", txd20, wexp);
      end
      if (txd20 !== wexp) bad_model++;
      for (int b = 0; b < 20; b++) bits[w*20+b] = txd20[b];
    end
    for (int k = 0; k + 127 < NWORDS * 20; k++) begin
      if (bits[k] !== bits[k+127]) bad_period++;
    end
    check("prbs_model", bad_model[19:0], 20'h0);
    check("prbs_vld", bad_vld[19:0], 20'h0);
    check("prbs_period", bad_period[19:0], 20'h0);
    check("prbs_mode", {18'h0, mode_act}, 20'h1);

    // Re-entry restarts from the seed
    tpmode = 2'b00; tick(); tick();
    tpmode = 2'b01; tick(); tick();
    check("prbs_reentry", txd20, w0);

    // Asynchronous reset mid-word
    tpmode = 2'b11; tick();
    check("mr_phase_pre", {19'h0, phase}, 20'h1);
    #2; rst = 1'b1; #1;
    check("mr_txd20", txd20, 20'h0);
    check("mr_vld", {19'h0, vld}, 20'h0);
    check("mr_phase", {19'h0, phase}, 20'h0);
    check("mr_mode", {18'h0, mode_act}, 20'h0);
    tick();
    rst = 1'b0; tpmode = 2'b00;
    txdi = 10'h005; tick();
    check("mr_vld_c1", {19'h0, vld}, 20'h0);
    txdi = 10'h006; tick();
    check("mr_vld_c2", {19'h0, vld}, 20'h1);
    check("mr_word", txd20, 20'h01805);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
